// File: rtl/crc16_tail.sv
// CRC-16 tail stage: re-emits one serial burst a cycle late on its own channel,
// appends the 16-bit CRC MSB first, and reports CRC, burst length and sticky errors.
module crc16_tail #(
  parameter logic [15:0] POLY = 16'h1021,
  parameter logic [15:0] INIT = 16'hFFFF
) (
  input  logic        clk_out16x,
  input  logic        rst_n,
  input  logic        crc_valid,
  input  logic [7:0]  data_in,
  input  logic [7:0]  vld_in,
  output logic [7:0]  ser_out,
  output logic [7:0]  ser_vld,
  output logic [15:0] crc_value,
  output logic [15:0] burst_len,
  output logic        crc_done,
  output logic [1:0]  err_status
);

  typedef enum logic [1:0] {IDLE, DATA, CRC} state_t;

  state_t      state, state_nx;
  logic [7:0]  ch_mask, start_mask;
  logic [15:0] crc, shift, len;
  logic [4:0]  cnt;
  logic        drop, start, cur_bit, start_bit, multi_hot;

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic b);
    crc_upd = {c[14:0], 1'b0} ^ ((c[15] ^ b) ? POLY : 16'h0000);
  endfunction

  always_comb begin
    start_mask = vld_in & (~vld_in + 8'd1);
    multi_hot  = (vld_in & (vld_in - 8'd1)) != 8'd0;
    cur_bit    = |(data_in & ch_mask);
    start_bit  = |(data_in & start_mask);
    // an overrun burst stays locked out until crc_valid has dropped once
    start      = (state == IDLE) && crc_valid && (vld_in != 8'd0) && !drop;
    state_nx   = state;
    case (state)
      IDLE:    if (start) state_nx = DATA;
      DATA:    if (!crc_valid) state_nx = CRC;
      CRC:     if (cnt == 5'd16) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_out16x or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk_out16x or negedge rst_n) begin
    if (!rst_n) begin
      ser_out    <= '0;
      ser_vld    <= '0;
      crc_value  <= '0;
      burst_len  <= '0;
      crc_done   <= 1'b0;
      err_status <= '0;
      ch_mask    <= '0;
      crc        <= '0;
      shift      <= '0;
      len        <= '0;
      cnt        <= '0;
      drop       <= 1'b0;
    end else begin
      crc_done <= 1'b0;
      if (state == CRC && crc_valid) begin
        drop          <= 1'b1;
        err_status[1] <= 1'b1;
      end else if (!crc_valid) begin
        drop <= 1'b0;
      end
      case (state)
        IDLE: begin
          ser_out <= '0;
          ser_vld <= '0;
          if (start) begin
            ch_mask <= start_mask;
            if (multi_hot) err_status[0] <= 1'b1;
            crc     <= crc_upd(INIT, start_bit);
            len     <= 16'd1;
            ser_out <= start_bit ? start_mask : 8'd0;
            ser_vld <= start_mask;
          end
        end
        DATA: begin
          if (crc_valid) begin
            crc     <= crc_upd(crc, cur_bit);
            len     <= (len == 16'hFFFF) ? len : len + 16'd1;
            ser_out <= cur_bit ? ch_mask : 8'd0;
          end else begin
            ser_out   <= crc[15] ? ch_mask : 8'd0;
            shift     <= {crc[14:0], 1'b0};
            cnt       <= 5'd1;
            burst_len <= len;
            crc_value <= crc;
          end
        end
        CRC: begin
          if (cnt == 5'd16) begin
            ser_out  <= '0;
            ser_vld  <= '0;
            crc_done <= 1'b1;
          end else begin
            ser_out <= shift[15] ? ch_mask : 8'd0;
            shift   <= {shift[14:0], 1'b0};
            cnt     <= cnt + 5'd1;
          end
        end
        default: begin
          ser_out <= '0;
          ser_vld <= '0;
        end
      endcase
    end
  end

endmodule
